// File: rtl/data_sync_pkg.sv
// Shared constants and types for the multi-channel bus synchroniser.
//   EVENT_LEVEL / EVENT_TOGGLE : values for the EVENT_MODE parameter
//   NUM_STAGES_MIN             : shallowest synchroniser chain accepted
//   ch_state_t                 : per-channel data-holding state
package data_sync_pkg;

  localparam int EVENT_LEVEL    = 0;
  localparam int EVENT_TOGGLE   = 1;
  localparam int NUM_STAGES_MIN = 2;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_t;

endpackage

// File: rtl/data_sync_ch.sv
// One channel of the bus synchroniser. It moves the asynchronous qualifier
// through a flop chain, detects an event on it, captures the held source bus,
// and tracks whether unread data is present and whether data was overwritten.
// Ports:
//   CLK, RST      destination clock, synchronous active-high reset
//   unsync_bus    source data, held stable by the source around the event
//   bus_enable    asynchronous qualifier (level or toggle, per EVENT_MODE)
//   clr_valid     consumer acknowledge, clears sync_valid and overrun
//   sync_bus      captured data
//   enable_pulse  one-cycle strobe aligned with the sync_bus update
//   sync_valid    unread data present
//   overrun       sticky: an event arrived while data was still unread
//   ack_toggle    flips on every capture, returned to the source domain
module data_sync_ch
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int EVENT_MODE = EVENT_LEVEL
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  input  logic                 clr_valid,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse,
  output logic                 sync_valid,
  output logic                 overrun,
  output logic                 ack_toggle
);

  if (NUM_STAGES < NUM_STAGES_MIN) begin : g_bad_stages
    $error("data_sync_ch: NUM_STAGES must be at least 2");
  end
  if (EVENT_MODE != EVENT_LEVEL && EVENT_MODE != EVENT_TOGGLE) begin : g_bad_mode
    $error("data_sync_ch: EVENT_MODE must be 0 (level) or 1 (toggle)");
  end

  // Synchroniser chain: flop-to-flop only, the CDC constraints key on this name.
  (* ASYNC_REG = "TRUE" *) logic [NUM_STAGES-1:0] sync_meta_q;
  logic                 prev_q;
  logic                 evt;
  logic [BUS_WIDTH-1:0] data_q;
  logic                 pulse_q;
  logic                 ack_q;
  ch_state_t            state_q, state_d;
  logic                 overrun_q, overrun_d;

  // Stage boundary: asynchronous input -> chain -> edge-history flop
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_meta_q <= '0;
      prev_q      <= 1'b0;
    end else begin
      sync_meta_q <= {sync_meta_q[NUM_STAGES-2:0], bus_enable};
      prev_q      <= sync_meta_q[NUM_STAGES-1];
    end
  end

  assign evt = (EVENT_MODE == EVENT_TOGGLE)
             ? (sync_meta_q[NUM_STAGES-1] ^ prev_q)
             : (sync_meta_q[NUM_STAGES-1] & ~prev_q);

  // Stage boundary: event -> capture register, strobe, ack and state
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q    <= '0;
      pulse_q   <= 1'b0;
      ack_q     <= 1'b0;
      state_q   <= CH_EMPTY;
      overrun_q <= 1'b0;
    end else begin
      pulse_q <= evt;
      if (evt) begin
        data_q <= unsync_bus;
        ack_q  <= ~ack_q;
      end
      state_q   <= state_d;
      overrun_q <= overrun_d;
    end
  end

  // A capture always wins over a same-cycle clear: the fresh data is unread.
  always_comb begin
    state_d   = state_q;
    overrun_d = overrun_q;
    case (state_q)
      CH_EMPTY: begin
        if (evt) state_d = CH_FULL;
      end
      CH_FULL: begin
        if (evt && !clr_valid) begin
          overrun_d = 1'b1;
        end else if (!evt && clr_valid) begin
          state_d   = CH_EMPTY;
          overrun_d = 1'b0;
        end
      end
    endcase
  end

  assign sync_bus     = data_q;
  assign enable_pulse = pulse_q;
  assign sync_valid   = (state_q == CH_FULL);
  assign overrun      = overrun_q;
  assign ack_toggle   = ack_q;

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel bus synchroniser into the CLK domain: NUM_CH independent
// data_sync_ch instances with the packed buses sliced per channel.
// Ports:
//   CLK, RST      destination clock, synchronous active-high reset
//   unsync_bus    source data, channel i at [i*BUS_WIDTH +: BUS_WIDTH]
//   bus_enable    per-channel asynchronous qualifier
//   clr_valid     per-channel consumer acknowledge
//   sync_bus      captured data, same packing as unsync_bus
//   enable_pulse  per-channel one-cycle capture strobe
//   sync_valid    per-channel unread-data flag
//   overrun       per-channel sticky overwrite flag
//   ack_toggle    per-channel capture toggle for the return handshake
module data_sync_mc
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int NUM_CH     = 2,
  parameter int EVENT_MODE = EVENT_LEVEL
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH-1:0]           clr_valid,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           sync_valid,
  output logic [NUM_CH-1:0]           overrun,
  output logic [NUM_CH-1:0]           ack_toggle
);

  if (NUM_CH < 1) begin : g_bad_ch
    $error("data_sync_mc: NUM_CH must be at least 1");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    data_sync_ch #(
      .BUS_WIDTH  (BUS_WIDTH),
      .NUM_STAGES (NUM_STAGES),
      .EVENT_MODE (EVENT_MODE)
    ) u_ch (
      .CLK          (CLK),
      .RST          (RST),
      .unsync_bus   (unsync_bus[i*BUS_WIDTH +: BUS_WIDTH]),
      .bus_enable   (bus_enable[i]),
      .clr_valid    (clr_valid[i]),
      .sync_bus     (sync_bus[i*BUS_WIDTH +: BUS_WIDTH]),
      .enable_pulse (enable_pulse[i]),
      .sync_valid   (sync_valid[i]),
      .overrun      (overrun[i]),
      .ack_toggle   (ack_toggle[i])
    );
  end

endmodule

// File: tb/tb_data_sync_mc.sv
module tb_data_sync_mc;

  typedef struct {
    int       ch;
    bit [7:0] d;
    bit       ack;
    int       cyc;
  } exp_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // DUT A: level mode, 2 stages, 2 channels
  logic        rst_a;
  logic [15:0] ub_a, sb_a;
  logic [1:0]  en_a, clr_a, ep_a, sv_a, ov_a, ak_a;
  // DUT T: toggle mode, 2 stages, 2 channels
  logic        rst_t;
  logic [15:0] ub_t, sb_t;
  logic [1:0]  en_t, clr_t, ep_t, sv_t, ov_t, ak_t;
  // DUT B: level mode, 3 stages, 4 channels
  logic        rst_b;
  logic [31:0] ub_b, sb_b;
  logic [3:0]  en_b, clr_b, ep_b, sv_b, ov_b, ak_b;

  data_sync_mc #(.BUS_WIDTH(8), .NUM_STAGES(2), .NUM_CH(2), .EVENT_MODE(0)) dut_a (
    .CLK(CLK), .RST(rst_a), .unsync_bus(ub_a), .bus_enable(en_a), .clr_valid(clr_a),
    .sync_bus(sb_a), .enable_pulse(ep_a), .sync_valid(sv_a), .overrun(ov_a), .ack_toggle(ak_a));

  data_sync_mc #(.BUS_WIDTH(8), .NUM_STAGES(2), .NUM_CH(2), .EVENT_MODE(1)) dut_t (
    .CLK(CLK), .RST(rst_t), .unsync_bus(ub_t), .bus_enable(en_t), .clr_valid(clr_t),
    .sync_bus(sb_t), .enable_pulse(ep_t), .sync_valid(sv_t), .overrun(ov_t), .ack_toggle(ak_t));

  data_sync_mc #(.BUS_WIDTH(8), .NUM_STAGES(3), .NUM_CH(4), .EVENT_MODE(0)) dut_b (
    .CLK(CLK), .RST(rst_b), .unsync_bus(ub_b), .bus_enable(en_b), .clr_valid(clr_b),
    .sync_bus(sb_b), .enable_pulse(ep_b), .sync_valid(sv_b), .overrun(ov_b), .ack_toggle(ak_b));

  exp_t qa[$], qt[$], qb[$];
  exp_t ea, et, eb;

  // Monitors: every strobe must match the oldest expected capture
  always @(negedge CLK) begin
    for (int c = 0; c < 2; c++) begin
      if (ep_a[c] === 1'b1) begin
        if (qa.size() == 0) chk("a_unexpected_pulse", 64'(ep_a[c]), 64'd0);
        else begin
          ea = qa.pop_front();
          chk("a_capture", {8'(c), sb_a[c*8 +: 8], 7'd0, ak_a[c], 32'(cyc)},
                           {8'(ea.ch), ea.d, 7'd0, ea.ack, 32'(ea.cyc)});
        end
      end
    end
  end

  always @(negedge CLK) begin
    for (int c = 0; c < 2; c++) begin
      if (ep_t[c] === 1'b1) begin
        if (qt.size() == 0) chk("t_unexpected_pulse", 64'(ep_t[c]), 64'd0);
        else begin
          et = qt.pop_front();
          chk("t_capture", {8'(c), sb_t[c*8 +: 8], 7'd0, ak_t[c], 32'(cyc)},
                           {8'(et.ch), et.d, 7'd0, et.ack, 32'(et.cyc)});
        end
      end
    end
  end

  always @(negedge CLK) begin
    for (int c = 0; c < 4; c++) begin
      if (ep_b[c] === 1'b1) begin
        if (qb.size() == 0) chk("b_unexpected_pulse", 64'(ep_b[c]), 64'd0);
        else begin
          eb = qb.pop_front();
          chk("b_capture", {8'(c), sb_b[c*8 +: 8], 7'd0, ak_b[c], 32'(cyc)},
                           {8'(eb.ch), eb.d, 7'd0, eb.ack, 32'(eb.cyc)});
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // 1: reset with random inputs
    rst_a = 1'b1; rst_t = 1'b1; rst_b = 1'b1;
    ub_a = 16'($urandom); en_a = 2'($urandom); clr_a = 2'($urandom);
    ub_t = 16'($urandom); en_t = 2'($urandom); clr_t = 2'($urandom);
    ub_b = $urandom;      en_b = 4'($urandom); clr_b = 4'($urandom);
    step(2);
    chk("rst_a_outputs", {sb_a, ep_a, sv_a, ov_a, ak_a}, 64'd0);
    chk("rst_t_outputs", {sb_t, ep_t, sv_t, ov_t, ak_t}, 64'd0);
    chk("rst_b_outputs", {sb_b, ep_b, sv_b, ov_b, ak_b}, 64'd0);
    en_a = '0; clr_a = '0; en_t = '0; clr_t = '0; en_b = '0; clr_b = '0;
    rst_a = 1'b0; rst_t = 1'b0; rst_b = 1'b0;
    step(5);
    chk("post_rst_a", {sb_a, ep_a, sv_a, ov_a, ak_a}, 64'd0);
    chk("post_rst_t", {sb_t, ep_t, sv_t, ov_t, ak_t}, 64'd0);
    chk("post_rst_b", {sb_b, ep_b, sv_b, ov_b, ak_b}, 64'd0);

    // 2: level event on ch0 of A, level held 4 cycles
    ub_a = 16'h55AA; en_a[0] = 1'b1;
    qa.push_back('{0, 8'hAA, 1'b1, cyc + 3});
    step(4);
    en_a[0] = 1'b0;
    step(4);
    chk("lvl_valid", 64'(sv_a), 64'h1);
    chk("lvl_ack", 64'(ak_a), 64'h1);
    chk("lvl_overrun", 64'(ov_a), 64'h0);
    chk("lvl_ch1_data", 64'(sb_a[15:8]), 64'h0);

    // 4: second event on ch0 with no clear -> overrun
    ub_a[7:0] = 8'h11; en_a[0] = 1'b1;
    qa.push_back('{0, 8'h11, 1'b0, cyc + 3});
    step(4);
    en_a[0] = 1'b0;
    step(4);
    chk("ovr_flags", {62'd0, sv_a[0], ov_a[0]}, 64'h3);
    chk("ovr_data", 64'(sb_a[7:0]), 64'h11);
    clr_a[0] = 1'b1;
    step(1);
    clr_a[0] = 1'b0;
    step(1);
    chk("clr_flags", {62'd0, sv_a[0], ov_a[0]}, 64'h0);
    // clear while empty has no effect
    clr_a[0] = 1'b1;
    step(1);
    clr_a[0] = 1'b0;
    step(1);
    chk("clr_empty", {62'd0, sv_a[0], ov_a[0]}, 64'h0);

    // 5: event and clear in the same cycle on ch1
    ub_a[15:8] = 8'h22; en_a[1] = 1'b1;
    qa.push_back('{1, 8'h22, 1'b1, cyc + 3});
    step(4);
    en_a[1] = 1'b0;
    step(4);
    chk("ch1_fill", {62'd0, sv_a[1], ov_a[1]}, 64'h2);
    ub_a[15:8] = 8'h33; en_a[1] = 1'b1;
    qa.push_back('{1, 8'h33, 1'b0, cyc + 3});
    step(2);
    clr_a[1] = 1'b1;
    step(1);
    clr_a[1] = 1'b0;
    step(3);
    en_a[1] = 1'b0;
    step(3);
    chk("evt_clr_same", {62'd0, sv_a[1], ov_a[1]}, 64'h2);
    chk("evt_clr_data", 64'(sb_a[15:8]), 64'h33);

    // 3: toggle mode on ch1 of T
    ub_t[15:8] = 8'hF0; en_t[1] = 1'b1;
    qt.push_back('{1, 8'hF0, 1'b1, cyc + 3});
    step(4);
    chk("tgl_first_ack", 64'(ak_t), 64'h2);
    ub_t[15:8] = 8'h0F; en_t[1] = 1'b0;
    qt.push_back('{1, 8'h0F, 1'b0, cyc + 3});
    step(4);
    chk("tgl_data", 64'(sb_t[15:8]), 64'h0F);
    chk("tgl_ack", 64'(ak_t), 64'h0);
    chk("tgl_flags", {60'd0, sv_t, ov_t}, 64'hA);

    // simultaneous events on all channels of B, 3-stage latency
    ub_b = 32'h44332211; en_b = 4'hF;
    for (int c = 0; c < 4; c++) qb.push_back('{c, 8'(c + 1) * 8'h11, 1'b1, cyc + 4});
    step(5);
    en_b = 4'h0;
    step(5);
    chk("all_ch_valid", 64'(sv_b), 64'hF);
    chk("all_ch_ack", 64'(ak_b), 64'hF);
    chk("all_ch_data", 64'(sb_b), 64'h44332211);

    // 6: reset mid-chain, A (2 stages) and B (3 stages)
    ub_a[7:0] = 8'h77; en_a[0] = 1'b1;
    ub_b[23:16] = 8'h5A; en_b[2] = 1'b1;
    step(1);
    rst_a = 1'b1; en_a = '0;
    rst_b = 1'b1; en_b = '0;
    step(2);
    rst_a = 1'b0; rst_b = 1'b0;
    step(6);
    chk("abort_a", {sb_a, ep_a, sv_a, ov_a, ak_a}, 64'd0);
    chk("abort_b", {sb_b, ep_b, sv_b, ov_b, ak_b}, 64'd0);

    chk("a_missing_pulses", 64'(qa.size()), 64'd0);
    chk("t_missing_pulses", 64'(qt.size()), 64'd0);
    chk("b_missing_pulses", 64'(qb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
